// File: rtl/state_list_pkg.sv
// Shared types and width helpers for the Sat Engine state-list control slice.
package state_list_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIND = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } an_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) r = r + 32'sd1;
    return r;
  endfunction

  // Encoded level index width; a single-level bin still needs one bit.
  function automatic int lvl_width(input int n);
    return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return (clog2(n + 32'sd1) < 32'sd1) ? 32'sd1 : clog2(n + 32'sd1);
  endfunction

endpackage

// File: rtl/lvl_prio_encode.sv
// Highest-set-bit encoder for the level-hit vector; yields 0 when nothing is set.
module lvl_prio_encode
  import state_list_pkg::*;
#(
  parameter int NUM_LVLS = 8,
  parameter int LW       = lvl_width(NUM_LVLS)
) (
  input  logic [NUM_LVLS-1:0] findindex_i,
  output logic [LW-1:0]       idx_o
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    idx_o = {LW{1'b0}};
    for (int i = 0; i < NUM_LVLS; i++) begin
      idx_o = findindex_i[i] ? LW'(i) : idx_o;
    end
  end

endmodule

// File: rtl/state_list_ctrl.sv
// State-list control core: imply convergence, conflict-analysis handshake,
// backtrack-level computation and base/current level bookkeeping.
module state_list_ctrl
  import state_list_pkg::*;
#(
  parameter int NUM_VARS      = 8,
  parameter int NUM_LVLS      = 8,
  parameter int WIDTH_LVL     = 16,
  parameter int STABLE_CYCLES = 1,
  parameter int MAX_ITERS     = 255,
  parameter int WIDTH_ITER    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          apply_imply_i,
  input  logic [NUM_VARS-1:0]           find_imply_i,
  input  logic [NUM_VARS-1:0]           find_conflict_i,
  output logic                          done_imply_o,
  output logic                          imply_timeout_o,
  output logic                          find_conflict_o,
  input  logic                          apply_analyze_i,
  output logic                          add_learntc_en_o,
  output logic                          done_analyze_o,
  output logic                          analyze_timeout_o,
  input  logic [NUM_LVLS-1:0]           findindex_i,
  input  logic [WIDTH_LVL-1:0]          max_lvl_i,
  input  logic                          base_lvl_en,
  input  logic [WIDTH_LVL-1:0]          base_lvl_i,
  input  logic [WIDTH_LVL-1:0]          cur_local_lvl_i,
  output logic [WIDTH_LVL-1:0]          cur_lvl_o,
  output logic [lvl_width(NUM_LVLS)-1:0] local_bkt_lvl_o,
  output logic [WIDTH_LVL-1:0]          bkt_lvl_o,
  output logic                          bkt_inter_bin_o,
  input  logic                          apply_bkt_cur_bin_i,
  output logic                          done_bkt_cur_bin_o,
  output logic                          busy_o,
  output logic                          req_error_o
);

  localparam int LW = lvl_width(NUM_LVLS);
  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam logic [SW-1:0]         STABLE_MAX = SW'(STABLE_CYCLES);
  localparam logic [WIDTH_ITER-1:0] ITER_MAX   = WIDTH_ITER'(MAX_ITERS);

  logic [NUM_VARS-1:0]   find_imply_pre_r;
  logic [NUM_VARS-1:0]   find_conflict_pre_r;
  logic [SW-1:0]         stab_cnt_r;
  logic [SW-1:0]         stab_nxt_s;
  logic [WIDTH_ITER-1:0] iter_cnt_r;
  logic [WIDTH_ITER-1:0] iter_nxt_s;
  logic                  done_nxt_s;
  logic                  done_imply_r;
  logic                  imply_timeout_r;

  an_state_e             state_r;
  logic [WIDTH_ITER-1:0] an_cnt_r;
  logic [WIDTH_ITER-1:0] an_cnt_nxt_s;
  logic                  an_to_flag_r;
  logic                  add_en_r;
  logic                  done_an_r;
  logic                  an_to_r;
  logic                  conflict_chg_s;

  logic [LW-1:0]         local_idx_s;
  logic [WIDTH_LVL-1:0]  base_lvl_r;
  logic [WIDTH_LVL-1:0]  bkt_lvl_r;
  logic                  bkt_inter_r;
  logic                  done_bkt_r;
  logic                  req_error_r;
  logic [1:0]            req_cnt_s;
  logic                  req_error_nxt_s;

  // Next-state values for the imply stability counter and watchdog.
  always_comb begin
    stab_nxt_s = {SW{1'b0}};
    iter_nxt_s = {WIDTH_ITER{1'b0}};
    if (!apply_imply_i || (find_imply_i != find_imply_pre_r)) begin
      stab_nxt_s = {SW{1'b0}};
    end else if (stab_cnt_r < STABLE_MAX) begin
      stab_nxt_s = stab_cnt_r + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      stab_nxt_s = stab_cnt_r;
    end
    if (!apply_imply_i) begin
      iter_nxt_s = {WIDTH_ITER{1'b0}};
    end else if (iter_cnt_r < ITER_MAX) begin
      iter_nxt_s = iter_cnt_r + {{(WIDTH_ITER-1){1'b0}}, 1'b1};
    end else begin
      iter_nxt_s = iter_cnt_r;
    end
    done_nxt_s = apply_imply_i && (stab_nxt_s >= STABLE_MAX);
  end

  // Imply convergence and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      find_imply_pre_r    <= {NUM_VARS{1'b0}};
      find_conflict_pre_r <= {NUM_VARS{1'b0}};
      stab_cnt_r          <= {SW{1'b0}};
      iter_cnt_r          <= {WIDTH_ITER{1'b0}};
      done_imply_r        <= 1'b0;
      imply_timeout_r     <= 1'b0;
    end else begin
      find_imply_pre_r    <= find_imply_i;
      find_conflict_pre_r <= find_conflict_i;
      stab_cnt_r          <= stab_nxt_s;
      iter_cnt_r          <= iter_nxt_s;
      done_imply_r        <= done_nxt_s;
      if (!apply_imply_i) begin
        imply_timeout_r <= 1'b0;
      end else if ((iter_nxt_s >= ITER_MAX) && !done_nxt_s) begin
        imply_timeout_r <= 1'b1;
      end else begin
        imply_timeout_r <= imply_timeout_r;
      end
    end
  end

  assign conflict_chg_s = (find_conflict_i != find_conflict_pre_r);
  assign an_cnt_nxt_s   = an_cnt_r + {{(WIDTH_ITER-1){1'b0}}, 1'b1};

  // Conflict-analysis handshake FSM; a change takes priority over the watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      an_cnt_r     <= {WIDTH_ITER{1'b0}};
      an_to_flag_r <= 1'b0;
      add_en_r     <= 1'b0;
      done_an_r    <= 1'b0;
      an_to_r      <= 1'b0;
    end else begin
      add_en_r  <= (state_r == ADD);
      done_an_r <= (state_r == DONE);
      an_to_r   <= (state_r == DONE) && an_to_flag_r;
      case (state_r)
        IDLE: begin
          if (apply_analyze_i) begin
            state_r      <= FIND;
            an_cnt_r     <= {WIDTH_ITER{1'b0}};
            an_to_flag_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        FIND: begin
          if (conflict_chg_s) begin
            state_r <= ADD;
          end else if (an_cnt_nxt_s >= ITER_MAX) begin
            state_r      <= DONE;
            an_to_flag_r <= 1'b1;
          end else begin
            an_cnt_r <= an_cnt_nxt_s;
          end
        end
        ADD:     state_r <= DONE;
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  lvl_prio_encode #(
    .NUM_LVLS (NUM_LVLS),
    .LW       (LW)
  ) u_prio (
    .findindex_i (findindex_i),
    .idx_o       (local_idx_s)
  );

  assign req_cnt_s = {1'b0, apply_imply_i} + {1'b0, apply_analyze_i} + {1'b0, apply_bkt_cur_bin_i};
  assign req_error_nxt_s = (req_cnt_s >= 2'd2) || (apply_analyze_i && (state_r != IDLE));

  // Base level, backtrack level and request bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_lvl_r  <= {WIDTH_LVL{1'b0}};
      bkt_lvl_r   <= {WIDTH_LVL{1'b0}};
      bkt_inter_r <= 1'b0;
      done_bkt_r  <= 1'b0;
      req_error_r <= 1'b0;
    end else begin
      if (base_lvl_en) begin
        base_lvl_r <= base_lvl_i;
      end else begin
        base_lvl_r <= base_lvl_r;
      end
      if (findindex_i == {NUM_LVLS{1'b0}}) begin
        bkt_lvl_r   <= max_lvl_i;
        bkt_inter_r <= 1'b1;
      end else begin
        bkt_lvl_r   <= base_lvl_r + WIDTH_LVL'(local_idx_s);
        bkt_inter_r <= 1'b0;
      end
      done_bkt_r  <= apply_bkt_cur_bin_i;
      req_error_r <= req_error_nxt_s;
    end
  end

  assign done_imply_o       = done_imply_r;
  assign imply_timeout_o    = imply_timeout_r;
  assign find_conflict_o    = |find_conflict_i;
  assign add_learntc_en_o   = add_en_r;
  assign done_analyze_o     = done_an_r;
  assign analyze_timeout_o  = an_to_r;
  assign cur_lvl_o          = base_lvl_r + cur_local_lvl_i;
  assign local_bkt_lvl_o    = local_idx_s;
  assign bkt_lvl_o          = bkt_lvl_r;
  assign bkt_inter_bin_o    = bkt_inter_r;
  assign done_bkt_cur_bin_o = done_bkt_r;
  assign busy_o             = apply_imply_i || (state_r != IDLE);
  assign req_error_o        = req_error_r;

endmodule

// File: doc/state_list_ctrl.md
# state_list_ctrl

Parametrised control core for the Sat Engine state list, generalising the fixed 8-variable / 8-level control to arbitrary NUM_VARS / NUM_LVLS. It sits between the var-state and lvl-state arrays and the engine sequencer, and owns four functions:
- imply-convergence detection, with a configurable stability window and an iteration watchdog;
- the conflict-analysis handshake FSM, with a timeout;
- backtrack-level computation through a parametrised priority encoder;
- the base-level register, current-level sum and backtrack done handshake.

## Interface
Parameters:
- NUM_VARS, 8, variables per bin (width of imply/conflict vectors)
- NUM_LVLS, 8, local levels per bin (width of findindex)
- WIDTH_LVL, 16, global level width
- STABLE_CYCLES, 1, consecutive unchanged imply samples required for done
- MAX_ITERS, 255, watchdog limit for imply and analyze (cycles)
- WIDTH_ITER, 8, watchdog counter width; must hold MAX_ITERS

Ports (LW = max(1, clog2(NUM_LVLS))):
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-low
- apply_imply_i  in  1  level request: run imply
- find_imply_i  in  NUM_VARS  per-variable implied flags from var states
- find_conflict_i  in  NUM_VARS  per-variable conflict flags
- done_imply_o  out  1  imply converged
- imply_timeout_o  out  1  imply watchdog expired
- find_conflict_o  out  1  OR of find_conflict_i
- apply_analyze_i  in  1  pulse: start conflict analysis
- add_learntc_en_o  out  1  one-cycle pulse: add learnt clause
- done_analyze_o  out  1  one-cycle pulse: analysis finished
- analyze_timeout_o  out  1  qualifies done_analyze_o: ended by timeout
- findindex_i  in  NUM_LVLS  level-hit vector from lvl states
- max_lvl_i  in  WIDTH_LVL  maximum level among learnt-clause vars
- base_lvl_en  in  1  load base level
- base_lvl_i  in  WIDTH_LVL  base level of current bin
- cur_local_lvl_i  in  WIDTH_LVL  local decision level from decision unit
- cur_lvl_o  out  WIDTH_LVL  base_lvl + cur_local_lvl
- local_bkt_lvl_o  out  LW  encoded findindex
- bkt_lvl_o  out  WIDTH_LVL  registered backtrack level
- bkt_inter_bin_o  out  1  registered: findindex was zero, inter-bin backtrack needed
- apply_bkt_cur_bin_i  in  1  request: backtrack inside current bin
- done_bkt_cur_bin_o  out  1  backtrack done
- busy_o  out  1  imply requested or analyze FSM not IDLE
- req_error_o  out  1  one-cycle pulse: illegal request overlap

## Operation
- Reset values: all registered outputs 0, FSM IDLE, base_lvl_r 0, all pre and counter registers 0.
- find_imply_pre and find_conflict_pre load their inputs every cycle.
- Imply stability counter:
  - cleared when apply_imply_i is low, or when find_imply_i != find_imply_pre;
  - otherwise increments, saturating at STABLE_CYCLES.
  - done_imply_o registered: high the cycle after a sample where apply_imply_i=1 and the counter's next value >= STABLE_CYCLES. It stays high while this holds; it is not a pulse.
- Imply watchdog:
  - counts apply_imply_i-high cycles; cleared when apply_imply_i is low;
  - on reaching MAX_ITERS without done, imply_timeout_o sets and stays set until apply_imply_i drops.
- Analyze FSM, states IDLE, FIND, ADD, DONE:
  - IDLE→FIND on apply_analyze_i.
  - FIND→ADD when find_conflict_i != find_conflict_pre.
  - FIND→DONE when the watchdog (cleared on entry to FIND) reaches MAX_ITERS; this also latches a timeout flag.
  - ADD→DONE and DONE→IDLE unconditionally.
  - add_learntc_en_o is high the cycle after state==ADD.
  - done_analyze_o is high the cycle after state==DONE; analyze_timeout_o equals the timeout flag in that same cycle and is 0 otherwise.
  - apply_analyze_i outside IDLE is ignored.
- Priority encoder: local_bkt_lvl_o = index of the highest set bit of findindex_i, or 0 if none.
- Backtrack level, registered every cycle:
  - findindex_i==0: bkt_lvl_o <= max_lvl_i and bkt_inter_bin_o <= 1;
  - otherwise bkt_lvl_o <= base_lvl_r + zero-extended local_bkt_lvl_o, modulo 2^WIDTH_LVL, and bkt_inter_bin_o <= 0.
- base_lvl_r loads base_lvl_i when base_lvl_en is high; otherwise it holds.
- cur_lvl_o is combinational, modulo 2^WIDTH_LVL.
- done_bkt_cur_bin_o is a one-cycle-delayed copy of apply_bkt_cur_bin_i.
- req_error_o is registered. It pulses when two or more of apply_imply_i, apply_analyze_i, apply_bkt_cur_bin_i are sampled high in the same cycle, or when apply_analyze_i is high outside IDLE. Each request is still processed normally.

## Timing
- Latencies:
  - done_imply_o: STABLE_CYCLES cycles after find_imply_i stops changing, plus 1 register cycle.
  - Analyze, best case: apply → FIND (1) → change seen → ADD → add_learntc_en_o (+1) → DONE → done_analyze_o (+1).
  - bkt_lvl_o and bkt_inter_bin_o: 1 cycle after findindex_i, max_lvl_i or base_lvl_r.
- Simultaneous base_lvl_en and findindex change: bkt_lvl_o uses the old base_lvl_r for one cycle, then the new one.
- Wrap-around: base 0xFFFF + local 3 gives 0x0002 (WIDTH_LVL=16), with no flag.
- Reset mid-analysis: the FSM returns to IDLE immediately on rst low. No done_analyze_o or add_learntc_en_o follows.

## Structure
- Package state_list_pkg holds:
  - the analyze-state enum {IDLE, FIND, ADD, DONE};
  - a clog2 helper function;
  - LW derivation.
- Sub-module lvl_prio_encode #(NUM_LVLS) implements the combinational highest-set-bit encoder. It is reused by lvl_state generations.

## Test plan
- Stable imply: NUM_VARS=8, STABLE_CYCLES=2, apply_imply_i=1, find_imply_i 0x00→0x03→0x03→0x03 → done_imply_o rises exactly 3 cycles after the value 0x03 first appears.
- Imply watchdog: MAX_ITERS=10, find_imply_i toggles every cycle under apply → imply_timeout_o high at cycle 10 and clears when apply drops; done_imply_o stays 0.
- Analyze normal: pulse apply_analyze_i, change find_conflict_i 0x00→0x10 two cycles later → add_learntc_en_o pulses once, then done_analyze_o pulses once the next cycle, with analyze_timeout_o=0.
- Analyze timeout: MAX_ITERS=10, find_conflict_i held constant → done_analyze_o and analyze_timeout_o both pulse in the same cycle, and add_learntc_en_o never fires.
- Backtrack level:
  - base_lvl 0x0020, findindex 0b00100100 → bkt_lvl_o=0x0025, bkt_inter_bin_o=0;
  - findindex 0, max_lvl_i 0x0011 → 0x0011, bkt_inter_bin_o=1;
  - base 0xFFFF, findindex 0x08 → 0x0002.
- Overlap and reset: apply_imply_i and apply_bkt_cur_bin_i high together → req_error_o pulses once. Assert rst while in FIND → all outputs 0 asynchronously, and the FSM is IDLE after release.
